// File: rtl/stereo_tx_fifo.sv
// Stereo transmit FIFO: parallel samples are written on wclk and shifted
// out MSB first on negedge rclk, alternating left/right channel per word.
// Pointers cross domains as Gray codes through two-flop synchronisers.
module stereo_tx_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int AF_LVL = 6
) (
    input  logic              wclk,
    input  logic              rst_,
    input  logic              rclk,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic [1:0]        fsize,
    input  logic              mute,
    input  logic              urun_clr,
    output logic              sd,
    output logic              ch,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              empty,
    output logic              underrun
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    // Inverting the two MSBs of the read Gray pointer gives the Gray value
    // the write pointer has when it is exactly one lap ahead.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] AF_THR    = PW'(AF_LVL);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Index of the MSB of a frame: 16, 24 or 32 bits (code 3 behaves as 32).
    function automatic logic [4:0] frame_maxp(input logic [1:0] fs);
        logic [4:0] m;
        case (fs)
            2'd0:    m = 5'd15;
            2'd1:    m = 5'd23;
            default: m = 5'd31;
        endcase
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [31:0]       rdata_s;

    // ------------------------------------------------------------------
    // Write domain state
    // ------------------------------------------------------------------
    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rq1_q, rq1_d;
    logic [PW-1:0] rq2_q, rq2_d;
    logic          full_q, full_d;
    logic          almost_full_q, almost_full_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wr_fire_s;
    logic [PW-1:0] rsync_bin_s;

    // ------------------------------------------------------------------
    // Read domain state
    // ------------------------------------------------------------------
    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] wq1_q, wq1_d;
    logic [PW-1:0] wq2_q, wq2_d;
    logic          empty_q, empty_d;
    logic [4:0]    bcnt_q, bcnt_d;
    logic [4:0]    maxp_q, maxp_d;
    logic          wch_q, wch_d;
    logic          valid_q, valid_d;
    logic          ch_q, ch_d;
    logic          sd_q, sd_d;
    logic          underrun_q, underrun_d;
    logic          word_start_s;
    logic          word_valid_s;
    logic          rd_adv_s;

    // Write port: store an accepted sample at the current write address.
    always_ff @(posedge wclk) begin
        if (wr_fire_s) begin
            mem[wbin_q[ADDR_W-1:0]] <= din;
        end
    end

    // Entry at the read address, zero-extended so bits above DATA_W-1 read 0.
    assign rdata_s = 32'(mem[rbin_q[ADDR_W-1:0]]);

    // Write-side next state: pointer advance, full, level and almost_full.
    always_comb begin
        wr_fire_s     = wr_en & ~full_q;
        wbin_d        = wbin_q + {{ADDR_W{1'b0}}, wr_fire_s};
        wgray_d       = bin2gray(wbin_d);
        rq1_d         = rgray_q;
        rq2_d         = rq1_q;
        rsync_bin_s   = gray2bin(rq2_q);
        full_d        = (wgray_d == (rq2_q ^ FULL_MASK));
        wlevel_d      = wbin_d - rsync_bin_s;
        almost_full_d = (wlevel_d >= AF_THR);
    end

    // Write-side registers, including the read-pointer synchroniser.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            wbin_q        <= {PW{1'b0}};
            wgray_q       <= {PW{1'b0}};
            rq1_q         <= {PW{1'b0}};
            rq2_q         <= {PW{1'b0}};
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            wlevel_q      <= {PW{1'b0}};
        end else begin
            wbin_q        <= wbin_d;
            wgray_q       <= wgray_d;
            rq1_q         <= rq1_d;
            rq2_q         <= rq2_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            wlevel_q      <= wlevel_d;
        end
    end

    // Read-side next state: bit counter, word validity, serial bit, channel,
    // underrun and read-pointer advance at the end of a valid word.
    always_comb begin
        wq1_d        = wgray_q;
        wq2_d        = wq1_q;
        maxp_d       = maxp_q;
        bcnt_d       = bcnt_q;
        wch_d        = wch_q;
        valid_d      = valid_q;
        ch_d         = 1'b0;
        sd_d         = 1'b0;
        rd_adv_s     = 1'b0;
        word_start_s = (bcnt_q == maxp_q);
        word_valid_s = valid_q;

        if (rd_en) begin
            // Validity is decided once, at the word start, and held.
            if (word_start_s) begin
                word_valid_s = ~empty_q;
            end else begin
                word_valid_s = valid_q;
            end
            valid_d = word_valid_s;
            sd_d    = word_valid_s & ~mute & rdata_s[bcnt_q];
            ch_d    = wch_q;
            if (bcnt_q == 5'd0) begin
                bcnt_d   = maxp_q;
                wch_d    = ~wch_q;
                rd_adv_s = word_valid_s;
            end else begin
                bcnt_d   = bcnt_q - 5'd1;
            end
        end else begin
            // Idle: frame size is only picked up here, so a change while
            // streaming takes effect after the next pause.
            maxp_d  = frame_maxp(fsize);
            bcnt_d  = frame_maxp(fsize);
            wch_d   = 1'b0;
            valid_d = 1'b0;
        end

        // A new underrun beats a simultaneous clear.
        if (rd_en && word_start_s && empty_q) begin
            underrun_d = 1'b1;
        end else if (urun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

        rbin_d  = rbin_q + {{ADDR_W{1'b0}}, rd_adv_s};
        rgray_d = bin2gray(rbin_d);
        empty_d = (rgray_d == wq2_q);
    end

    // Read-side registers on the falling bit clock, including the
    // write-pointer synchroniser.
    always_ff @(negedge rclk or negedge rst_) begin
        if (!rst_) begin
            rbin_q     <= {PW{1'b0}};
            rgray_q    <= {PW{1'b0}};
            wq1_q      <= {PW{1'b0}};
            wq2_q      <= {PW{1'b0}};
            empty_q    <= 1'b1;
            bcnt_q     <= 5'd31;
            maxp_q     <= 5'd31;
            wch_q      <= 1'b0;
            valid_q    <= 1'b0;
            ch_q       <= 1'b0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            wq1_q      <= wq1_d;
            wq2_q      <= wq2_d;
            empty_q    <= empty_d;
            bcnt_q     <= bcnt_d;
            maxp_q     <= maxp_d;
            wch_q      <= wch_d;
            valid_q    <= valid_d;
            ch_q       <= ch_d;
            sd_q       <= sd_d;
            underrun_q <= underrun_d;
        end
    end

    assign sd          = sd_q;
    assign ch          = ch_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign wlevel      = wlevel_q;
    assign empty       = empty_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_stereo_tx_fifo.sv
// Scoreboard bench for stereo_tx_fifo: written words are queued, a monitor
// on the bit clock rebuilds each frame and compares it with the queue head.
module tb_stereo_tx_fifo;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              wclk = 1'b0;
    logic              rclk = 1'b0;
    logic              rst_ = 1'b0;
    logic              wr_en = 1'b0;
    logic [31:0]       din = 32'd0;
    logic              rd_en = 1'b0;
    logic [1:0]        fsize = 2'd0;
    logic              mute = 1'b0;
    logic              urun_clr = 1'b0;
    logic              sd, ch, full, almost_full, empty, underrun;
    logic [ADDR_W:0]   wlevel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sbq [$];

    // Monitor state
    logic        rd_cap = 1'b0;
    logic        mute_cap = 1'b0;
    logic [1:0]  fs_cap = 2'd0;
    int          mon_len = 32;
    int          mon_pos = 0;
    int          mon_frames = 0;
    int          mon_inflight = 0;
    logic        mon_valid = 1'b0;
    logic        mon_chexp = 1'b0;
    logic        ch_and = 1'b1;
    logic        ch_or = 1'b0;
    logic [31:0] mon_word = 32'd0;
    logic [31:0] mon_exp = 32'd0;
    logic [31:0] mon_act = 32'd0;
    bit          rnd_done = 1'b0;

    stereo_tx_fifo #(.DATA_W(32), .ADDR_W(ADDR_W), .AF_LVL(6)) dut (
        .wclk(wclk), .rst_(rst_), .rclk(rclk), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .fsize(fsize), .mute(mute), .urun_clr(urun_clr),
        .sd(sd), .ch(ch), .full(full), .almost_full(almost_full),
        .wlevel(wlevel), .empty(empty), .underrun(underrun)
    );

    always #7 wclk = ~wclk;
    always #3 rclk = ~rclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int flen(input logic [1:0] f);
        return (f == 2'd0) ? 16 : (f == 2'd1) ? 24 : 32;
    endfunction

    // Capture read-side controls at the same edge the design samples them.
    always @(negedge rclk or negedge rst_) begin
        if (!rst_) begin
            rd_cap   <= 1'b0;
            mute_cap <= 1'b0;
            fs_cap   <= 2'd0;
        end else begin
            rd_cap   <= rd_en;
            mute_cap <= mute;
            fs_cap   <= fsize;
        end
    end

    // Monitor: rebuild frames from sd/ch and compare against the scoreboard.
    always @(posedge rclk or negedge rst_) begin
        if (!rst_) begin
            mon_len      = 32;
            mon_pos      = 0;
            mon_valid    = 1'b0;
            mon_chexp    = 1'b0;
            mon_inflight = 0;
        end else if (!rd_cap) begin
            mon_len      = flen(fs_cap);
            mon_pos      = 0;
            mon_chexp    = 1'b0;
            mon_inflight = 0;
            chk("idle_sd", 64'(sd), 64'd0);
        end else begin
            if (mon_pos == 0) begin
                mon_exp = 32'd0;
                mon_act = 32'd0;
                ch_and  = 1'b1;
                ch_or   = 1'b0;
                if (sbq.size() > 0) begin
                    mon_word     = sbq.pop_front();
                    mon_valid    = 1'b1;
                    mon_inflight = 1;
                end else begin
                    mon_word  = 32'd0;
                    mon_valid = 1'b0;
                    chk("underrun_set", 64'(underrun), 64'd1);
                end
            end
            mon_exp[mon_len-1-mon_pos] = mon_valid & ~mute_cap & mon_word[mon_len-1-mon_pos];
            mon_act[mon_len-1-mon_pos] = sd;
            ch_and = ch_and & ch;
            ch_or  = ch_or | ch;
            mon_pos++;
            if (mon_pos == mon_len) begin
                chk("frame_data", 64'(mon_act), 64'(mon_exp));
                chk("frame_ch", 64'({ch_and, ch_or}), 64'({mon_chexp, mon_chexp}));
                mon_pos      = 0;
                mon_chexp    = ~mon_chexp;
                mon_frames++;
                mon_inflight = 0;
            end
        end
    end

    task automatic write_word(input logic [31:0] d, input bit accept);
        @(negedge wclk);
        wr_en = 1'b1;
        din   = d;
        @(posedge wclk);
        #1;
        wr_en = 1'b0;
        if (accept) sbq.push_back(d);
    endtask

    task automatic wait_r(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    // Stream n whole frames, stopping rd_en right at a frame boundary.
    task automatic run_frames(input int n, input int budget);
        int target;
        int cyc;
        target = mon_frames + n;
        cyc = 0;
        @(posedge rclk);
        #1;
        rd_en = 1'b1;
        do begin
            @(posedge rclk);
            #1;
            cyc++;
        end while (!(mon_frames == target && mon_pos == 0) && cyc < budget);
        rd_en = 1'b0;
        chk("run_frames_done", 64'(mon_frames), 64'(target));
    endtask

    task automatic random_writer(input int nwords);
        int cnt;
        int guard;
        cnt = 0;
        guard = 0;
        while (cnt < nwords && guard < 40000) begin
            @(negedge wclk);
            guard++;
            if (!full && ($urandom_range(0, 1) == 1)) begin
                chk("no_overflow", 64'((sbq.size() + mon_inflight) < DEPTH), 64'd1);
                wr_en = 1'b1;
                din   = $urandom;
                @(posedge wclk);
                #1;
                sbq.push_back(din);
                wr_en = 1'b0;
                cnt++;
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        chk("writer_done", 64'(cnt), 64'(nwords));
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, checked while rst_ is held low.
        repeat (4) @(posedge wclk);
        #1;
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_af", 64'(almost_full), 64'd0);
        chk("rst_wlevel", 64'(wlevel), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_sd", 64'(sd), 64'd0);
        chk("rst_ch", 64'(ch), 64'd0);
        wait_r(1);
        rst_ = 1'b1;
        wait_r(4);

        // Two 16-bit frames: left then right, then the FIFO is empty.
        fsize = 2'd0;
        write_word(32'hA5A5_0001, 1'b1);
        write_word(32'h0000_FFFF, 1'b1);
        wait_r(10);
        run_frames(2, 200);
        wait_r(2);
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_sbq", 64'(sbq.size()), 64'd0);
        repeat (4) @(posedge wclk);
        #1;
        chk("t1_wlevel_drained", 64'(wlevel), 64'd0);

        // Fill to full with no reads; the ninth write must be dropped.
        for (int i = 1; i <= 8; i++) begin
            write_word($urandom, 1'b1);
            chk("fill_wlevel", 64'(wlevel), 64'(i));
            chk("fill_full", 64'(full), 64'(i == 8));
            chk("fill_af", 64'(almost_full), 64'(i >= 6));
        end
        write_word(32'hDEAD_BEEF, 1'b0);
        chk("ovf_wlevel", 64'(wlevel), 64'd8);
        chk("ovf_full", 64'(full), 64'd1);
        fsize = 2'd2;
        wait_r(10);
        run_frames(8, 400);
        wait_r(2);
        chk("t2_empty", 64'(empty), 64'd1);

        // Underrun: two zero frames with ch toggling, then clear.
        fsize = 2'd0;
        wait_r(3);
        run_frames(2, 200);
        wait_r(1);
        chk("urun_sticky", 64'(underrun), 64'd1);
        chk("urun_empty", 64'(empty), 64'd1);
        urun_clr = 1'b1;
        wait_r(1);
        urun_clr = 1'b0;
        chk("urun_cleared", 64'(underrun), 64'd0);

        // 24-bit frames; a mid-stream size change waits for the next pause.
        fsize = 2'd1;
        write_word(32'h00AB_CDEF, 1'b1);
        write_word(32'h0012_3456, 1'b1);
        wait_r(10);
        fork
            run_frames(2, 200);
            begin
                wait_r(5);
                fsize = 2'd0;
            end
        join
        write_word(32'h7777_BEEF, 1'b1);
        wait_r(10);
        run_frames(1, 100);

        // Mute during a word: zeros while muted, word still consumed.
        fsize = 2'd2;
        write_word(32'h1234_5678, 1'b1);
        write_word(32'h9ABC_DEF0, 1'b1);
        wait_r(10);
        fork
            run_frames(2, 200);
            begin
                wait_r(9);
                mute = 1'b1;
                wait_r(10);
                mute = 1'b0;
            end
        join
        wait_r(2);
        chk("mute_consumed_empty", 64'(empty), 64'd1);
        chk("mute_sbq", 64'(sbq.size()), 64'd0);

        // Reset pulse in the middle of the second (right) word.
        write_word(32'hCAFE_0001, 1'b1);
        write_word(32'hCAFE_0002, 1'b1);
        wait_r(10);
        rd_en = 1'b1;
        wait_r(40);
        chk("pre_rst_ch", 64'(ch), 64'd1);
        rst_  = 1'b0;
        rd_en = 1'b0;
        sbq.delete();
        #1;
        chk("mid_rst_sd", 64'(sd), 64'd0);
        chk("mid_rst_ch", 64'(ch), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_full", 64'(full), 64'd0);
        chk("mid_rst_wlevel", 64'(wlevel), 64'd0);
        chk("mid_rst_underrun", 64'(underrun), 64'd0);
        wait_r(5);
        rst_ = 1'b1;
        wait_r(4);
        write_word(32'h0BAD_F00D, 1'b1);
        wait_r(10);
        run_frames(1, 100);

        // Random traffic, 1000 words, random frame size per chunk, random mute.
        fork
            random_writer(1000);
            begin
                int g;
                g = 0;
                while (!full && g < 500) begin
                    @(posedge wclk);
                    g++;
                end
                #1;
                chk("rnd_fill", 64'(full), 64'd1);
                for (int c = 0; c < 10; c++) begin
                    fsize = 2'($urandom_range(0, 3));
                    wait_r(2);
                    run_frames(100, 4000);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge rclk);
                    #1;
                    if ($urandom_range(0, 19) == 0) mute = ~mute;
                end
                mute = 1'b0;
            end
        join
        wait_r(2);
        chk("rnd_sbq_empty", 64'(sbq.size()), 64'd0);
        chk("rnd_no_underrun", 64'(underrun), 64'd0);
        chk("rnd_empty", 64'(empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
